// File: rtl/fpga_spi_pkg.sv
// Shared constants, FSM state type and status-word packing for the SPI status
// readback transmitter.
package fpga_spi_pkg;

  localparam int SPI_WORD_BITS = 16;
  localparam int FRAME_ERR_BIT = 15;
  localparam int STICKY_LSB    = 8;
  localparam int STICKY_BITS   = 7;
  localparam int STATUS_BITS   = 8;
  localparam int CNT_W         = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    END   = 2'd3
  } tx_state_e;

  function automatic logic [SPI_WORD_BITS-1:0] build_word(
    input logic                   ferr,
    input logic [STICKY_BITS-1:0] sticky,
    input logic [STATUS_BITS-1:0] status
  );
    logic [SPI_WORD_BITS-1:0] w;
    w                             = '0;
    w[FRAME_ERR_BIT]              = ferr;
    w[STICKY_LSB +: STICKY_BITS]  = sticky;
    w[STATUS_BITS-1:0]            = status;
    return w;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous SPI pin, plus a delay flop that
// yields single-cycle rise/fall strobes in the pck0 domain.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic pck0,
  input  logic nrst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   dly_r;

  // synchronizer chain and edge-detect delay flop
  always_ff @(posedge pck0 or negedge nrst) begin
    if (!nrst) begin
      sync_r <= {SYNC_STAGES{RST_VAL}};
      dly_r  <= RST_VAL;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], din};
      dly_r  <= sync_r[SYNC_STAGES-1];
    end
  end

  assign level = sync_r[SYNC_STAGES-1];
  assign rise  = level & ~dly_r;
  assign fall  = ~level & dly_r;

endmodule

// File: rtl/spi_status_tx.sv
// SPI status readback transmitter: snapshots sticky event flags, framing error
// and a live status byte at frame start and shifts them out on miso.
module spi_status_tx
  import fpga_spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int WORD_BITS   = SPI_WORD_BITS
) (
  input  logic                   pck0,
  input  logic                   nrst,
  input  logic                   spck,
  input  logic                   ncs,
  output logic                   miso,
  input  logic [STATUS_BITS-1:0] status_in,
  input  logic [STICKY_BITS-1:0] event_in,
  output logic                   tx_busy,
  output logic                   frame_done
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORD_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WORD_BITS + 1);

  tx_state_e                state_r;
  logic [SPI_WORD_BITS-1:0] shift_r;
  logic [CNT_W-1:0]         bit_cnt_r;
  logic [STICKY_BITS-1:0]   sticky_r;
  logic [STICKY_BITS-1:0]   snap_r;
  logic                     frame_err_r;
  logic                     armed_r;
  logic [1:0]               warm_r;

  logic                     spck_level_unused_s;
  logic                     spck_rise_s;
  logic                     spck_fall_s;
  logic                     ncs_lvl_s;
  logic                     ncs_rise_s;
  logic                     ncs_fall_s;
  logic [SPI_WORD_BITS-1:0] word_s;
  logic                     cnt_full_s;
  logic [STICKY_BITS-1:0]   clr_s;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_spck_sync (
    .pck0  (pck0),
    .nrst  (nrst),
    .din   (spck),
    .level (spck_level_unused_s),
    .rise  (spck_rise_s),
    .fall  (spck_fall_s)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ncs_sync (
    .pck0  (pck0),
    .nrst  (nrst),
    .din   (ncs),
    .level (ncs_lvl_s),
    .rise  (ncs_rise_s),
    .fall  (ncs_fall_s)
  );

  assign word_s     = build_word(frame_err_r, sticky_r, status_in);
  assign cnt_full_s = (bit_cnt_r == CNT_FULL);
  // only flags that were actually reported get cleared, and only on a good frame
  assign clr_s      = ((state_r == END) && cnt_full_s) ? snap_r : '0;

  // sticky event accumulation; a new event beats a simultaneous clear
  always_ff @(posedge pck0 or negedge nrst) begin
    if (!nrst) begin
      sticky_r <= '0;
    end else begin
      sticky_r <= (sticky_r & ~clr_s) | event_in;
    end
  end

  // frame FSM with shift register, bit counter and registered outputs
  always_ff @(posedge pck0 or negedge nrst) begin
    if (!nrst) begin
      state_r     <= IDLE;
      shift_r     <= '0;
      bit_cnt_r   <= '0;
      snap_r      <= '0;
      frame_err_r <= 1'b0;
      armed_r     <= 1'b0;
      warm_r      <= 2'b00;
      miso        <= 1'b0;
      tx_busy     <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      warm_r     <= {warm_r[0], 1'b1};
      frame_done <= 1'b0;
      case (state_r)
        IDLE: begin
          miso    <= 1'b0;
          tx_busy <= 1'b0;
          // arm only once the ncs chain holds a genuine post-reset high sample
          if (!armed_r) begin
            if (warm_r[1] && ncs_lvl_s) begin
              armed_r <= 1'b1;
            end
          end else if (ncs_fall_s) begin
            state_r <= LOAD;
          end
        end
        LOAD: begin
          shift_r   <= word_s;
          miso      <= word_s[SPI_WORD_BITS-1];
          snap_r    <= sticky_r;
          bit_cnt_r <= '0;
          tx_busy   <= 1'b1;
          state_r   <= SHIFT;
        end
        SHIFT: begin
          if (ncs_rise_s) begin
            state_r <= END;
          end else if (spck_rise_s) begin
            if (bit_cnt_r != CNT_SAT) begin
              bit_cnt_r <= bit_cnt_r + CNT_W'(1);
            end
          end else if (spck_fall_s) begin
            shift_r <= {shift_r[SPI_WORD_BITS-2:0], 1'b0};
            miso    <= shift_r[SPI_WORD_BITS-2];
          end
        end
        END: begin
          if (cnt_full_s) begin
            frame_done  <= 1'b1;
            frame_err_r <= 1'b0;
          end else begin
            frame_err_r <= 1'b1;
          end
          miso    <= 1'b0;
          tx_busy <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_status_tx.sv
// Randomized bench for spi_status_tx: an ARM-side SPI master plus a word-level
// model of the sticky flags, framing error and status snapshot.
module tb_spi_status_tx;

  logic       pck0 = 1'b0;
  logic       nrst;
  logic       spck;
  logic       ncs;
  logic       miso;
  logic [7:0] status_in;
  logic [6:0] event_in;
  logic       tx_busy;
  logic       frame_done;

  int         errors = 0;
  int         checks = 0;
  logic [6:0] m_sticky;
  logic       m_ferr;

  spi_status_tx #(.SYNC_STAGES(2), .WORD_BITS(16)) dut (
    .pck0       (pck0),
    .nrst       (nrst),
    .spck       (spck),
    .ncs        (ncs),
    .miso       (miso),
    .status_in  (status_in),
    .event_in   (event_in),
    .tx_busy    (tx_busy),
    .frame_done (frame_done)
  );

  always #10 pck0 = ~pck0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge pck0);
    #1;
  endtask

  task automatic pulse_event(input logic [6:0] m);
    tick(1);
    event_in = m;
    tick(1);
    event_in = 7'd0;
    m_sticky = m_sticky | m;
  endtask

  // one spck period at 3 MHz: 8 pck0 cycles high, 8 low
  task automatic spi_bit();
    spck = 1'b1;
    tick(8);
    spck = 1'b0;
    tick(8);
  endtask

  task automatic run_frame(input string tag, input int nbits, input logic [6:0] end_ev,
                           input bit chg, input logic [7:0] new_status);
    logic [15:0] word;
    logic [31:0] rx;
    logic [31:0] exp_rx;
    int          fd_cnt;
    int          fd_k;
    word = {m_ferr, m_sticky, status_in};
    tick(1);
    ncs = 1'b0;
    tick(6);
    if (chg) status_in = new_status;
    tick(2);
    rx     = 32'd0;
    exp_rx = 32'd0;
    for (int i = 0; i < nbits; i++) begin
      rx     = {rx[30:0], miso};
      exp_rx = {exp_rx[30:0], (i < 16) ? word[15-i] : 1'b0};
      if (i == 0) check_val({tag, " busy"}, 32'(tx_busy), 32'd1);
      spi_bit();
    end
    check_val({tag, " rx"}, rx, exp_rx);
    if (nbits == 16) check_val({tag, " miso_tail"}, 32'(miso), 32'd0);
    ncs    = 1'b1;
    fd_cnt = 0;
    fd_k   = 0;
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      if (k == 3) event_in = end_ev;
      if (k == 4) event_in = 7'd0;
      if (frame_done) begin
        fd_cnt++;
        if (fd_k == 0) fd_k = k;
      end
    end
    if (nbits == 16) begin
      check_val({tag, " done_cnt"}, 32'(fd_cnt), 32'd1);
      check_val({tag, " done_lat"}, 32'(fd_k), 32'd4);
      m_sticky = (m_sticky & ~word[14:8]) | end_ev;
      m_ferr   = 1'b0;
    end else begin
      check_val({tag, " no_done"}, 32'(fd_cnt), 32'd0);
      m_sticky = m_sticky | end_ev;
      m_ferr   = 1'b1;
    end
    check_val({tag, " idle_busy"}, 32'(tx_busy), 32'd0);
    check_val({tag, " idle_miso"}, 32'(miso), 32'd0);
  endtask

  initial begin
    logic [15:0] word;
    logic [31:0] rx;
    int          fd_cnt;
    int          nb;
    logic [6:0]  ev;

    nrst      = 1'b0;
    spck      = 1'b0;
    ncs       = 1'b1;
    status_in = 8'h00;
    event_in  = 7'd0;
    m_sticky  = 7'd0;
    m_ferr    = 1'b0;

    tick(3);
    check_val("rst miso", 32'(miso), 32'd0);
    check_val("rst busy", 32'(tx_busy), 32'd0);
    check_val("rst done", 32'(frame_done), 32'd0);
    nrst = 1'b1;
    tick(5);

    // event 3 reported once, then cleared
    status_in = 8'hA5;
    pulse_event(7'h08);
    run_frame("t1", 16, 7'd0, 1'b0, 8'h00);
    run_frame("t1b", 16, 7'd0, 1'b0, 8'h00);

    // event on the clear cycle survives
    pulse_event(7'h08);
    run_frame("t2", 16, 7'h08, 1'b0, 8'h00);
    status_in = 8'h3C;
    run_frame("t2b", 16, 7'd0, 1'b0, 8'h00);

    // short frame flags framing error for exactly one following frame
    run_frame("t3a", 12, 7'd0, 1'b0, 8'h00);
    run_frame("t3b", 16, 7'd0, 1'b0, 8'h00);
    run_frame("t3c", 16, 7'd0, 1'b0, 8'h00);

    // reset in the middle of a frame
    status_in = 8'h5A;
    pulse_event(7'h41);
    word = {m_ferr, m_sticky, status_in};
    tick(1);
    ncs = 1'b0;
    tick(8);
    rx = 32'd0;
    for (int i = 0; i < 7; i++) begin
      rx = {rx[30:0], miso};
      spi_bit();
    end
    check_val("t4 rx7", rx, {25'd0, word[15:9]});
    nrst = 1'b0;
    #1;
    check_val("t4 rst_miso", 32'(miso), 32'd0);
    check_val("t4 rst_busy", 32'(tx_busy), 32'd0);
    tick(3);
    nrst     = 1'b1;
    m_sticky = 7'd0;
    m_ferr   = 1'b0;
    for (int i = 0; i < 9; i++) spi_bit();
    check_val("t4 orphan_busy", 32'(tx_busy), 32'd0);
    ncs    = 1'b1;
    fd_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      tick(1);
      if (frame_done) fd_cnt++;
    end
    check_val("t4 orphan_done", 32'(fd_cnt), 32'd0);
    run_frame("t4b", 16, 7'd0, 1'b0, 8'h00);

    // status change after LOAD only affects the next frame
    status_in = 8'h11;
    run_frame("t5a", 16, 7'd0, 1'b1, 8'hEE);
    run_frame("t5b", 16, 7'd0, 1'b0, 8'h00);

    // spck activity with ncs high is ignored
    fd_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      spck = ~spck;
      for (int k = 0; k < 5; k++) begin
        tick(1);
        if (frame_done) fd_cnt++;
      end
      check_val("t6 miso", 32'(miso), 32'd0);
      check_val("t6 busy", 32'(tx_busy), 32'd0);
    end
    check_val("t6 done", 32'(fd_cnt), 32'd0);
    spck = 1'b0;
    tick(4);
    run_frame("t6b", 16, 7'd0, 1'b0, 8'h00);

    // randomized frames, lengths, status bytes and event timing
    for (int r = 0; r < 10; r++) begin
      status_in = 8'($urandom);
      pulse_event(7'($urandom));
      nb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 20)) : 16;
      ev = ($urandom_range(0, 1) == 1) ? 7'($urandom) : 7'd0;
      run_frame("rnd", nb, ev, 1'b0, 8'h00);
    end
    run_frame("final", 16, 7'd0, 1'b0, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
